// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM encodings,
// cascade-cell seed values and the committed result record.
package serial_mag_comparator_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Before any bit is seen the operands are equal and neither is greater.
  localparam logic E_INIT = 1'b1;
  localparam logic G_INIT = 1'b0;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

  function automatic cmp_res_t res_from(input logic e, input logic g);
    cmp_res_t r;
    r.eq = e;
    r.gt = g;
    r.lt = ~e & ~g;
    return r;
  endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Request/result bundle for the serial magnitude comparator.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (output start, a_in, b_in, input busy, done, eq, gt, lt);
  modport slave  (input start, a_in, b_in, output busy, done, eq, gt, lt);
endinterface

// File: rtl/cmp_bit_cell.sv
// One-bit cascade compare cell, MSB-first: carries the "still equal" and
// "already greater" state from the higher bits into this bit.
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  input  logic e_in,
  input  logic g_in,
  output logic e_out,
  output logic g_out
);
  assign e_out = e_in & ~(a ^ b);
  assign g_out = g_in | (e_in & a & ~b);
endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: latches A/B on start, walks them MSB-first
// through a single cascade cell, and commits eq/gt/lt after WIDTH bits.
module serial_mag_comparator
  import serial_mag_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_mag_comparator_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             e;
  logic             g;
  logic             e_nxt;
  logic             g_nxt;
  cmp_res_t         res;

  cmp_bit_cell u_cell (
    .a     (a_sr[WIDTH-1]),
    .b     (b_sr[WIDTH-1]),
    .e_in  (e),
    .g_in  (g),
    .e_out (e_nxt),
    .g_out (g_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      e     <= E_INIT;
      g     <= G_INIT;
      res   <= '0;
    end else begin
      case (state)
        // DONE accepts a new request just like IDLE so back-to-back compares
        // run at one result every WIDTH+1 cycles.
        IDLE, DONE: begin
          if (bus.start) begin
            a_sr  <= bus.a_in;
            b_sr  <= bus.b_in;
            e     <= E_INIT;
            g     <= G_INIT;
            cnt   <= CW'(WIDTH - 1);
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          e    <= e_nxt;
          g    <= g_nxt;
          a_sr <= a_sr << 1;
          b_sr <= b_sr << 1;
          if (cnt == '0) begin
            res   <= res_from(e_nxt, g_nxt);
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.eq   = res.eq;
  assign bus.gt   = res.gt;
  assign bus.lt   = res.lt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator at WIDTH=8 and WIDTH=2, with a
// transaction-level reference model checked every cycle.
module tb_serial_mag_comparator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_mag_comparator_if #(.WIDTH(8)) b8();
  serial_mag_comparator_if #(.WIDTH(2)) b2();

  serial_mag_comparator #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_mag_comparator #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input int a, input int b);
    if (a == b) return 3'b100;
    if (a > b)  return 3'b010;
    return 3'b001;
  endfunction

  // Reference model: a request accepted while not busy produces the integer
  // comparison of the operands seen at acceptance, WIDTH cycles later.
  int         wd[2]     = '{8, 2};
  int         m_left[2] = '{0, 0};
  logic       m_done[2] = '{1'b0, 1'b0};
  logic [2:0] m_res[2]  = '{3'b000, 3'b000};
  logic [2:0] m_pend[2] = '{3'b000, 3'b000};
  logic       st[2];
  int         av[2];
  int         bv[2];

  always_comb begin
    st[0] = b8.start; av[0] = int'(b8.a_in); bv[0] = int'(b8.b_in);
    st[1] = b2.start; av[1] = int'(b2.a_in); bv[1] = int'(b2.b_in);
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_left[i] <= 0;
        m_done[i] <= 1'b0;
        m_res[i]  <= 3'b000;
      end else if (m_left[i] != 0) begin
        m_left[i] <= m_left[i] - 1;
        m_done[i] <= (m_left[i] == 1);
        if (m_left[i] == 1) m_res[i] <= m_pend[i];
      end else begin
        m_done[i] <= 1'b0;
        if (st[i]) begin
          m_left[i] <= wd[i];
          m_pend[i] <= ref_cmp(av[i], bv[i]);
        end
      end
    end
  end

  function automatic logic [4:0] dut_vec(input int sel);
    if (sel == 0) return {b8.busy, b8.done, b8.eq, b8.gt, b8.lt};
    return {b2.busy, b2.done, b2.eq, b2.gt, b2.lt};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("model_w%0d", wd[i]), int'(dut_vec(i)),
            int'({m_left[i] != 0, m_done[i], m_res[i]}));
      check($sformatf("busy_done_excl_w%0d", wd[i]), int'(dut_vec(i)[4] & dut_vec(i)[3]), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int sel, input logic s, input int a, input int b);
    if (sel == 0) begin
      b8.start = s; b8.a_in = a[7:0]; b8.b_in = b[7:0];
    end else begin
      b2.start = s; b2.a_in = a[1:0]; b2.b_in = b[1:0];
    end
  endtask

  function automatic logic get_done(input int sel);
    return dut_vec(sel)[3];
  endfunction

  // Wait for done; returns cycles waited since the current position.
  task automatic wait_done(input int sel, output int n);
    n = 0;
    while (!get_done(sel) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input int sel, input int a, input int b, input logic [2:0] exp,
                     input string nm);
    int n;
    set_req(sel, 1'b1, a, b);
    tick();
    set_req(sel, 1'b0, a, b);
    wait_done(sel, n);
    check({nm, "_latency"}, n, wd[sel]);
    check({nm, "_result"}, int'(dut_vec(sel)[2:0]), int'(exp));
    tick();
    check({nm, "_done_pulse"}, int'(get_done(sel)), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b0, 0, 0);
    repeat (3) tick();
    check("reset_outputs", int'(dut_vec(0)), 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_after_reset", int'(dut_vec(0)), 0);

    run(0, 8'hA5, 8'hA5, 3'b100, "equal_a5");
    repeat (3) tick();
    check("equal_held", int'(dut_vec(0)), 5'b00100);
    run(0, 8'h80, 8'h7F, 3'b010, "msb_gt");
    run(0, 8'h00, 8'h80, 3'b001, "msb_lt");

    // Operand change and stray start while busy must not disturb the compare.
    set_req(0, 1'b1, 8'h3C, 8'h3D);
    tick();
    set_req(0, 1'b0, 8'h3C, 8'h3D);
    repeat (2) tick();
    set_req(0, 1'b1, 8'hFF, 8'h3D);
    tick();
    set_req(0, 1'b0, 8'hFF, 8'h3D);
    wait_done(0, n);
    check("isolate_latency", n, 5);
    check("isolate_result", int'(dut_vec(0)[2:0]), 3'b001);
    tick();
    check("isolate_single_done", int'(dut_vec(0)[4:3]), 0);
    repeat (3) tick();

    // Back-to-back with start held high.
    set_req(0, 1'b1, 8'h10, 8'h08);
    tick();
    wait_done(0, n);
    check("b2b_first_latency", n, 8);
    check("b2b_first_result", int'(dut_vec(0)[2:0]), 3'b010);
    set_req(0, 1'b1, 8'h01, 8'h08);
    tick();
    check("b2b_accept_in_done", int'(dut_vec(0)[4]), 1);
    wait_done(0, n);
    check("b2b_second_gap", n + 1, 9);
    check("b2b_second_result", int'(dut_vec(0)[2:0]), 3'b001);
    set_req(0, 1'b0, 8'h01, 8'h08);
    repeat (2) tick();

    // Reset during the 4th SHIFT cycle.
    set_req(0, 1'b1, 8'h12, 8'h34);
    tick();
    set_req(0, 1'b0, 8'h12, 8'h34);
    repeat (3) tick();
    check("pre_abort_busy", int'(dut_vec(0)[4]), 1);
    #2 rst_n = 1'b0;
    #1 check("abort_async_clear", int'(dut_vec(0)), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("abort_no_done", int'(dut_vec(0)), 0);
    run(0, 8'h55, 8'h55, 3'b100, "fresh_after_abort");

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        run(1, a, b, ref_cmp(a, b), $sformatf("w2_%0d_%0d", a, b));
    check("w2_lit_3_1_gt", int'(ref_cmp(3, 1)), 3'b010);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Sequential, bit-serial magnitude comparator built around a one-bit cascade compare cell.
- Latches two WIDTH-bit operands and walks them MSB-first, one bit per clock, keeping the running equal/greater state in flip-flops.
- Reports eq/gt/lt with a start/busy/done handshake.
- Sequential wrapper and driver for the existing combinational cascade cell.

Parameters:
WIDTH, 8, operand width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a compare; sampled on rising clk.
a_in  input  WIDTH  operand A, sampled only on an accepted start.
b_in  input  WIDTH  operand B, sampled only on an accepted start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when a result is committed.
eq  output  1  committed result: A == B.
gt  output  1  committed result: A > B.
lt  output  1  committed result: A < B.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy=0, done=0, eq=0, gt=0, lt=0.
  - Shift registers and bit counter cleared.
  - Deassertion is sampled on the next rising clk.
- FSM states: IDLE, SHIFT, DONE. Encodings are 2-bit localparams from the shared include.
- IDLE:
  - start=1 -> load a_sr<=a_in, b_sr<=b_in, e<=1, g<=0, cnt<=WIDTH-1; go to SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT (busy=1):
  - Each edge feeds a_sr[MSB] and b_sr[MSB] with the registered e/g into the cell.
  - Cell equations: e_next = e & ~(a^b); g_next = g | (e & a & ~b).
  - e<=e_next, g<=g_next; both shift registers shift left by 1; cnt<=cnt-1.
  - On the edge where cnt==0: commit eq<=e_next, gt<=g_next, lt<=~e_next&~g_next; go to DONE.
- DONE (done=1 for exactly one cycle, busy=0):
  - start=1 -> accept a new compare exactly as in IDLE (back-to-back operation); next state SHIFT.
  - start=0 -> next state IDLE.
- Latency: with start sampled at edge k, bits are processed at edges k+1..k+WIDTH. done is high in the cycle after edge k+WIDTH. Throughput is one compare per WIDTH+1 cycles.
- Latency is fixed: no early termination, even once g=1 or e=0.
- Result holding:
  - eq/gt/lt change only at commit and hold until the next commit or reset.
  - They are not updated from intermediate e/g.
  - After the first commit, exactly one of eq/gt/lt is 1.
- start during SHIFT is ignored: no restart and no operand resample.
- a_in/b_in changes after an accepted start have no effect.
- done and busy are never high together.
- WIDTH=1: a single SHIFT cycle, with cnt==0 on entry.
- The counter is sized to hold WIDTH-1. It never wraps, because it is reloaded on every accept.
- Reset asserted mid-SHIFT aborts immediately:
  - No done pulse.
  - eq/gt/lt forced to 0.
  - The next accepted start behaves as a fresh compare.

Decomposition:
- Shared include (cmp_defs.vh):
  - FSM state localparams IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Cascade-cell initial values E_INIT=1, G_INIT=0.
- Sub-module cmp_bit_cell: purely combinational one-bit cascade cell.
  - Inputs a, b, e_in, g_in; outputs e_out, g_out; equations as above.
  - Instantiated once.
  - Verified standalone against the existing 16-entry cascade vector set.
- Top holds FSM, counter, shift registers and result registers. Target about 150-200 lines.

Test Plan:
- Reset: rst_n=0 with clk running -> busy=done=eq=gt=lt=0; hold start=0 after release -> outputs stay 0, state stays IDLE.
- Equal: WIDTH=8, a_in=8'hA5, b_in=8'hA5, start one cycle -> busy=1 for 8 cycles, then done=1 for 1 cycle; eq=1, gt=0, lt=0, held until the next commit.
- MSB decides: a_in=8'h80, b_in=8'h7F -> gt=1; a_in=8'h00, b_in=8'h80 -> lt=1; done exactly 8 clocks after the start edge in both cases.
- LSB decides plus operand isolation: a_in=8'h3C, b_in=8'h3D, start; change a_in to 8'hFF and pulse start during busy -> result lt=1, exactly one done pulse, no restart.
- Back-to-back: start held high continuously with a_in=8'h10 then 8'h01 (b_in=8'h08) -> first commit gt=1; start accepted in the DONE cycle; second commit lt=1 exactly 9 clocks after the first done.
- Reset mid-operation plus exhaustive check:
  - Assert rst_n=0 on cycle 4 of SHIFT -> busy, done and results drop to 0 asynchronously; no done pulse appears; a new start (8'h55 vs 8'h55) gives eq=1.
  - WIDTH=2: sweep all 16 a/b pairs -> eq/gt/lt match integer comparison.
